abro_stim_gen: RTL and testbench

- Stimulus initiator for an ABRO-style event controller. The target waits for event A, then event B, then raises a sticky O until its active-low reset.
- This block drives the target's A/B event inputs and its restart line, then observes O.
- It runs a programmable number of runs and reports pass/fail counts.
- Sits beside the target controller in the self-test wrapper; a host or bench pulses start and reads the counters.

---
 rtl/abro_pkg.sv | 28 ++
 rtl/abro_delay_cnt.sv | 28 ++
 rtl/abro_stim_gen.sv | 173 +++++++++++++++++
 tb/tb_abro_stim_gen.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/abro_pkg.sv
// abro_pkg: shared state/order encodings and counter sizing helpers
// for the ABRO stimulus generator.
package abro_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RESTART = 3'd1,
        ST_FIRST   = 3'd2,
        ST_GAP     = 3'd3,
        ST_SECOND  = 3'd4,
        ST_WAIT_O  = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    localparam logic [1:0] ORD_AB  = 2'b00;
    localparam logic [1:0] ORD_BA  = 2'b01;
    localparam logic [1:0] ORD_SIM = 2'b10;

    // Bits needed to hold a cycle count of n (timeout counter width).
    function automatic int to_cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    function automatic int max_w(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/abro_delay_cnt.sv
// abro_delay_cnt: loadable down-counter with a zero flag, shared by the
// restart, gap and timeout phases of the stimulus generator.
module abro_delay_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/abro_stim_gen.sv
// abro_stim_gen: drives A/B events and restart into an ABRO target,
// watches its O output and tallies pass/fail over a batch of runs.
module abro_stim_gen
    import abro_pkg::*;
#(
    parameter int GAP_W      = 8,
    parameter int RUN_W      = 8,
    parameter int TIMEOUT    = 16,
    parameter int RST_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       order,
    input  logic [GAP_W-1:0] gap,
    input  logic [RUN_W-1:0] num_runs,
    input  logic             o_in,
    output logic             a_out,
    output logic             b_out,
    output logic             dut_reset_n,
    output logic             busy,
    output logic             done,
    output logic [RUN_W-1:0] pass_cnt,
    output logic [RUN_W-1:0] fail_cnt,
    output logic [2:0]       state
);

    localparam int TO_W = to_cnt_w(TIMEOUT);
    localparam int RS_W = to_cnt_w(RST_CYCLES);
    localparam int CW   = max_w(GAP_W, max_w(TO_W, RS_W));

    localparam logic [CW-1:0] RST_LD = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LD  = CW'(TIMEOUT - 1);

    state_t           st;
    state_t           nxt;
    logic [1:0]       ord_q;
    logic [GAP_W-1:0] gap_q;
    logic [RUN_W-1:0] runs_q;
    logic [RUN_W-1:0] run_idx;
    logic             early;

    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_zero;
    logic [CW-1:0]    cnt_val;

    logic             run_end;
    logic             last_run;

    // Early O wins over a real O: such a run is a fail on its first wait cycle.
    assign run_end  = (st == ST_WAIT_O) && (o_in || early || cnt_zero);
    assign last_run = (run_idx + RUN_W'(1)) == runs_q;
    assign cnt_dec  = (st == ST_RESTART) || (st == ST_GAP) || (st == ST_WAIT_O);
    assign state    = st;

    abro_delay_cnt #(
        .W(CW)
    ) u_dly (
        .clk     (clk),
        .reset   (reset),
        .load    (cnt_load),
        .dec     (cnt_dec),
        .load_val(cnt_val),
        .zero    (cnt_zero)
    );

    always_comb begin
        nxt      = st;
        cnt_load = 1'b0;
        cnt_val  = '0;
        case (st)
            ST_IDLE: begin
                if (start) begin
                    nxt      = ST_RESTART;
                    cnt_load = 1'b1;
                    cnt_val  = RST_LD;
                end
            end
            ST_RESTART: begin
                if (cnt_zero) nxt = ST_FIRST;
            end
            ST_FIRST: begin
                if (ord_q == ORD_SIM) begin
                    nxt      = ST_WAIT_O;
                    cnt_load = 1'b1;
                    cnt_val  = TO_LD;
                end else if (gap_q != '0) begin
                    nxt      = ST_GAP;
                    cnt_load = 1'b1;
                    cnt_val  = CW'(gap_q - GAP_W'(1));
                end else begin
                    nxt = ST_SECOND;
                end
            end
            ST_GAP: begin
                if (cnt_zero) nxt = ST_SECOND;
            end
            ST_SECOND: begin
                nxt      = ST_WAIT_O;
                cnt_load = 1'b1;
                cnt_val  = TO_LD;
            end
            ST_WAIT_O: begin
                if (run_end) begin
                    if (last_run) begin
                        nxt = ST_DONE;
                    end else begin
                        nxt      = ST_RESTART;
                        cnt_load = 1'b1;
                        cnt_val  = RST_LD;
                    end
                end
            end
            ST_DONE: nxt = ST_IDLE;
            default: nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st          <= ST_IDLE;
            a_out       <= 1'b0;
            b_out       <= 1'b0;
            dut_reset_n <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass_cnt    <= '0;
            fail_cnt    <= '0;
            ord_q       <= ORD_AB;
            gap_q       <= '0;
            runs_q      <= '0;
            run_idx     <= '0;
            early       <= 1'b0;
        end else begin
            st          <= nxt;
            a_out       <= (nxt == ST_FIRST && ord_q != ORD_BA) ||
                           (nxt == ST_SECOND && ord_q == ORD_BA);
            b_out       <= (nxt == ST_FIRST && ord_q != ORD_AB) ||
                           (nxt == ST_SECOND && ord_q == ORD_AB);
            dut_reset_n <= (nxt != ST_RESTART);
            busy        <= (nxt != ST_IDLE);
            done        <= (nxt == ST_DONE);

            if (st == ST_IDLE && start) begin
                ord_q    <= (order == 2'b11) ? ORD_AB : order;
                gap_q    <= gap;
                runs_q   <= (num_runs == '0) ? RUN_W'(1) : num_runs;
                pass_cnt <= '0;
                fail_cnt <= '0;
                run_idx  <= '0;
                early    <= 1'b0;
            end

            if (st == ST_RESTART) begin
                early <= 1'b0;
            end else if (o_in && (st == ST_FIRST || st == ST_GAP ||
                                  st == ST_SECOND)) begin
                early <= 1'b1;
            end

            if (run_end) begin
                if (o_in && !early) begin
                    if (pass_cnt != '1) pass_cnt <= pass_cnt + RUN_W'(1);
                end else begin
                    if (fail_cnt != '1) fail_cnt <= fail_cnt + RUN_W'(1);
                end
                run_idx <= run_idx + RUN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_abro_stim_gen.sv
// tb_abro_stim_gen: scoreboard bench with an ABRO target model for
// abro_stim_gen.
module tb_abro_stim_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] order;
    logic [7:0] gap;
    logic [7:0] num_runs;
    logic       o_in;
    logic       a_out;
    logic       b_out;
    logic       dut_reset_n;
    logic       busy;
    logic       done;
    logic [7:0] pass_cnt;
    logic [7:0] fail_cnt;
    logic [2:0] state;

    abro_stim_gen #(
        .GAP_W     (8),
        .RUN_W     (8),
        .TIMEOUT   (16),
        .RST_CYCLES(2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .order      (order),
        .gap        (gap),
        .num_runs   (num_runs),
        .o_in       (o_in),
        .a_out      (a_out),
        .b_out      (b_out),
        .dut_reset_n(dut_reset_n),
        .busy       (busy),
        .done       (done),
        .pass_cnt   (pass_cnt),
        .fail_cnt   (fail_cnt),
        .state      (state)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Target: sticky O after A then B; optionally accepts A and B together.
    logic tgt_a    = 1'b0;
    logic tgt_o    = 1'b0;
    logic sim_ok   = 1'b0;
    logic o_force  = 1'b0;

    always @(posedge clk) begin
        if (!dut_reset_n) begin
            tgt_a <= 1'b0;
            tgt_o <= 1'b0;
        end else begin
            if (a_out) tgt_a <= 1'b1;
            if (b_out && (tgt_a || (a_out && sim_ok))) tgt_o <= 1'b1;
        end
    end

    assign o_in = tgt_o | o_force;

    typedef struct {
        int         rst_len;
        logic [1:0] p1;
        logic [1:0] p2;
        int         sp;
        int         wl;
        bit         pass;
    } run_t;

    run_t sb[$];
    int   exp_p = 0;
    int   exp_f = 0;
    int   done_seen = 0;

    function automatic run_t mk(input logic [1:0] ord, input int g,
                                input bit pass, input int wl);
        run_t r;
        r.rst_len = 2;
        r.wl      = wl;
        r.pass    = pass;
        if (ord == 2'b01) begin
            r.p1 = 2'b01; r.p2 = 2'b10; r.sp = g + 1;
        end else if (ord == 2'b10) begin
            r.p1 = 2'b11; r.p2 = 2'b00; r.sp = 0;
        end else begin
            r.p1 = 2'b10; r.p2 = 2'b01; r.sp = g + 1;
        end
        return r;
    endfunction

    task automatic push(input int n, input run_t r);
        for (int i = 0; i < n; i++) sb.push_back(r);
    endtask

    // Monitor: measures each run and checks it against the scoreboard.
    int         cyc = 0;
    int         t1 = 0;
    int         rl = 0;
    int         wl = 0;
    int         sp = 0;
    int         stray = 0;
    logic [1:0] p1 = 2'b00;
    logic [1:0] p2 = 2'b00;
    logic [2:0] prev = 3'd0;

    always @(negedge clk) begin
        run_t r;
        cyc++;
        if (done) done_seen++;
        if (!reset) begin
            prev = 3'd0; rl = 0; wl = 0; sp = 0; stray = 0;
        end else begin
            if (prev == 3'd5 && state != 3'd5) begin
                if (sb.size() == 0) begin
                    chk("sb_empty", 1, 0);
                end else begin
                    r = sb.pop_front();
                    chk("rst_len", rl, r.rst_len);
                    chk("ev_first", p1, r.p1);
                    chk("ev_second", p2, r.p2);
                    chk("spacing", sp, r.sp);
                    chk("wait_len", wl, r.wl);
                    chk("stray", stray, 0);
                    if (r.pass) exp_p++;
                    else exp_f++;
                    chk("pass_cnt", pass_cnt, exp_p);
                    chk("fail_cnt", fail_cnt, exp_f);
                end
                rl = 0; wl = 0; stray = 0;
            end
            case (state)
                3'd1: if (!dut_reset_n) rl++;
                3'd2: begin
                    p1 = {a_out, b_out}; p2 = 2'b00; t1 = cyc; sp = 0;
                end
                3'd4: begin
                    p2 = {a_out, b_out}; sp = cyc - t1;
                end
                3'd5: wl++;
                default: ;
            endcase
            if (state inside {3'd2, 3'd3, 3'd4, 3'd5} && !dut_reset_n)
                stray++;
            if (!(state inside {3'd2, 3'd4}) && (a_out || b_out))
                stray++;
            prev = state;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_batch(input logic [1:0] ord, input int g,
                               input int n);
        order     = ord;
        gap       = 8'(g);
        num_runs  = 8'(n);
        start     = 1'b1;
        exp_p     = 0;
        exp_f     = 0;
        done_seen = 0;
        tick(1);
        start = 1'b0;
        chk("busy_start", busy, 1);
    endtask

    task automatic finish_batch(input int np, input int nf);
        int n = 0;
        while (done_seen == 0 && n < 3000) begin
            tick(1);
            n++;
        end
        tick(3);
        chk("done_cnt", done_seen, 1);
        chk("busy_end", busy, 0);
        chk("idle", state, 0);
        chk("rstn_idle", dut_reset_n, 1);
        chk("pass_tot", pass_cnt, np);
        chk("fail_tot", fail_cnt, nf);
        chk("sb_left", sb.size(), 0);
    endtask

    task automatic wait_state(input logic [2:0] s);
        int n = 0;
        while (state !== s && n < 500) begin
            tick(1);
            n++;
        end
        if (state !== s) chk("wait_state", state, s);
    endtask

    initial begin
        int n;
        reset    = 1'b0;
        start    = 1'b0;
        order    = 2'b00;
        gap      = 8'd0;
        num_runs = 8'd0;
        tick(3);
        chk("rst_state", state, 0);
        chk("rst_a", a_out, 0);
        chk("rst_b", b_out, 0);
        chk("rst_rstn", dut_reset_n, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass_cnt, 0);
        chk("rst_fail", fail_cnt, 0);
        reset = 1'b1;
        tick(3);

        // A then B with gap 3; a stray start mid-batch must be ignored.
        push(4, mk(2'b00, 3, 1'b1, 1));
        start_batch(2'b00, 3, 4);
        n = 0;
        while (pass_cnt != 8'd2 && n < 500) begin
            tick(1);
            n++;
        end
        chk("mid_pass", pass_cnt, 2);
        order    = 2'b01;
        num_runs = 8'd1;
        start    = 1'b1;
        tick(1);
        start = 1'b0;
        finish_batch(4, 0);

        // B then A with no gap: target never fires, every run times out.
        push(3, mk(2'b01, 0, 1'b0, 16));
        start_batch(2'b01, 0, 3);
        finish_batch(0, 3);

        // Simultaneous events, target rejecting then accepting them.
        sim_ok = 1'b0;
        push(1, mk(2'b10, 0, 1'b0, 16));
        start_batch(2'b10, 0, 1);
        finish_batch(0, 1);
        sim_ok = 1'b1;
        push(1, mk(2'b10, 0, 1'b1, 1));
        start_batch(2'b10, 0, 1);
        finish_batch(1, 0);
        sim_ok = 1'b0;

        // Order 11 acts as A then B; O forced during the first gap.
        push(1, mk(2'b11, 5, 1'b0, 1));
        push(1, mk(2'b11, 5, 1'b1, 1));
        start_batch(2'b11, 5, 2);
        wait_state(3'd3);
        o_force = 1'b1;
        tick(1);
        o_force = 1'b0;
        finish_batch(1, 1);

        // num_runs of zero runs once.
        push(1, mk(2'b00, 0, 1'b1, 1));
        start_batch(2'b00, 0, 0);
        finish_batch(1, 0);

        // Reset pulled in the middle of a wait phase.
        push(3, mk(2'b01, 0, 1'b0, 16));
        start_batch(2'b01, 0, 3);
        n = 0;
        while (fail_cnt != 8'd1 && n < 500) begin
            tick(1);
            n++;
        end
        chk("pre_rst_fail", fail_cnt, 1);
        wait_state(3'd5);
        tick(3);
        reset = 1'b0;
        #1;
        chk("arst_rstn", dut_reset_n, 0);
        chk("arst_a", a_out, 0);
        chk("arst_b", b_out, 0);
        chk("arst_busy", busy, 0);
        chk("arst_fail", fail_cnt, 0);
        chk("arst_pass", pass_cnt, 0);
        chk("arst_state", state, 0);
        sb.delete();
        tick(2);
        done_seen = 0;
        reset = 1'b1;
        tick(40);
        chk("no_done", done_seen, 0);
        chk("post_state", state, 0);
        chk("post_busy", busy, 0);
        chk("post_rstn", dut_reset_n, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
